// File: rtl/rw_bus_arbiter.sv
// Round-robin arbiter sharing one cache-side memory bus between the I-cache and D-cache.
// One transaction in flight; the owner holds the bus until its read burst or write completes.
module rw_bus_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int BURST_LEN  = 8,
    parameter int RW_BIT     = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_reqcyc,
    input  logic [DATA_WIDTH-1:0] i_req,
    input  logic [DATA_WIDTH-1:0] i_reqdata,
    input  logic [TAG_WIDTH-1:0]  i_reqtag,
    output logic                  i_reqack,
    output logic                  i_respcyc,
    output logic [DATA_WIDTH-1:0] i_resp,
    output logic [TAG_WIDTH-1:0]  i_resptag,
    input  logic                  i_respack,
    output logic                  i_writeack,
    input  logic                  d_reqcyc,
    input  logic [DATA_WIDTH-1:0] d_req,
    input  logic [DATA_WIDTH-1:0] d_reqdata,
    input  logic [TAG_WIDTH-1:0]  d_reqtag,
    output logic                  d_reqack,
    output logic                  d_respcyc,
    output logic [DATA_WIDTH-1:0] d_resp,
    output logic [TAG_WIDTH-1:0]  d_resptag,
    input  logic                  d_respack,
    output logic                  d_writeack,
    output logic                  m_reqcyc,
    output logic [DATA_WIDTH-1:0] m_req,
    output logic [DATA_WIDTH-1:0] m_reqdata,
    output logic [TAG_WIDTH-1:0]  m_reqtag,
    input  logic                  m_reqack,
    input  logic                  m_respcyc,
    input  logic [DATA_WIDTH-1:0] m_resp,
    input  logic [TAG_WIDTH-1:0]  m_resptag,
    output logic                  m_respack,
    input  logic                  m_writeack
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, REQ, RD_RESP, WR_WAIT} state_t;

    state_t                  state, state_nx;
    logic                    owner_d;   // owner is meaningful only outside IDLE
    logic                    last_d;
    logic [CW-1:0]           beat_cnt;
    logic [DATA_WIDTH-1:0]   lat_req, lat_data;
    logic [TAG_WIDTH-1:0]    lat_tag;

    logic grant, grant_d, beat, done, resp_ack;

    always_comb begin
        state_nx   = state;
        grant      = 1'b0;
        grant_d    = 1'b0;
        beat       = 1'b0;
        done       = 1'b0;
        resp_ack   = 1'b0;
        i_reqack   = 1'b0;
        i_respcyc  = 1'b0;
        i_resp     = '0;
        i_resptag  = '0;
        i_writeack = 1'b0;
        d_reqack   = 1'b0;
        d_respcyc  = 1'b0;
        d_resp     = '0;
        d_resptag  = '0;
        d_writeack = 1'b0;
        m_reqcyc   = 1'b0;
        m_req      = '0;
        m_reqdata  = '0;
        m_reqtag   = '0;
        m_respack  = 1'b0;
        // Outputs are held at zero while reset is asserted, even before the edge.
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (i_reqcyc || d_reqcyc) begin
                        grant    = 1'b1;
                        grant_d  = d_reqcyc && (!i_reqcyc || !last_d);
                        state_nx = REQ;
                    end
                end
                REQ: begin
                    m_reqcyc  = 1'b1;
                    m_req     = lat_req;
                    m_reqdata = lat_data;
                    m_reqtag  = lat_tag;
                    if (m_reqack) begin
                        d_reqack = owner_d;
                        i_reqack = !owner_d;
                        state_nx = lat_tag[RW_BIT] ? RD_RESP : WR_WAIT;
                    end
                end
                RD_RESP: begin
                    resp_ack  = (owner_d ? d_respack : i_respack) && m_respcyc;
                    m_respack = resp_ack;
                    if (owner_d) begin
                        d_respcyc = m_respcyc;
                        d_resp    = m_resp;
                        d_resptag = m_resptag;
                    end else begin
                        i_respcyc = m_respcyc;
                        i_resp    = m_resp;
                        i_resptag = m_resptag;
                    end
                    beat = resp_ack;
                    if (beat && beat_cnt == LAST_BEAT) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end
                end
                WR_WAIT: begin
                    if (m_writeack) begin
                        d_writeack = owner_d;
                        i_writeack = !owner_d;
                        done       = 1'b1;
                        state_nx   = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner_d  <= 1'b0;
            last_d   <= 1'b0;
            beat_cnt <= '0;
            lat_req  <= '0;
            lat_data <= '0;
            lat_tag  <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner_d  <= grant_d;
                lat_req  <= grant_d ? d_req     : i_req;
                lat_data <= grant_d ? d_reqdata : i_reqdata;
                lat_tag  <= grant_d ? d_reqtag  : i_reqtag;
            end
            if (beat) begin
                beat_cnt <= done ? '0 : beat_cnt + 1'b1;
            end
            if (done) begin
                last_d <= owner_d;
            end
        end
    end

endmodule

// File: tb/tb_rw_bus_arbiter.sv
// Directed bench for rw_bus_arbiter: reads, writes, stalls, arbitration order and
// mid-transaction reset, each compared against hand-computed values.
module tb_rw_bus_arbiter;

    localparam int BURST = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_reqcyc, i_reqack, i_respcyc, i_respack, i_writeack;
    logic [63:0] i_req, i_reqdata, i_resp;
    logic [12:0] i_reqtag, i_resptag;
    logic        d_reqcyc, d_reqack, d_respcyc, d_respack, d_writeack;
    logic [63:0] d_req, d_reqdata, d_resp;
    logic [12:0] d_reqtag, d_resptag;
    logic        m_reqcyc, m_reqack, m_respcyc, m_respack, m_writeack;
    logic [63:0] m_req, m_reqdata, m_resp;
    logic [12:0] m_reqtag, m_resptag;

    int n_assert = 0;
    int n_fail   = 0;

    rw_bus_arbiter #(.DATA_WIDTH(64), .TAG_WIDTH(13), .BURST_LEN(BURST), .RW_BIT(12)) dut (
        .clk(clk), .reset(reset),
        .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqdata(i_reqdata), .i_reqtag(i_reqtag),
        .i_reqack(i_reqack), .i_respcyc(i_respcyc), .i_resp(i_resp), .i_resptag(i_resptag),
        .i_respack(i_respack), .i_writeack(i_writeack),
        .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqdata(d_reqdata), .d_reqtag(d_reqtag),
        .d_reqack(d_reqack), .d_respcyc(d_respcyc), .d_resp(d_resp), .d_resptag(d_resptag),
        .d_respack(d_respack), .d_writeack(d_writeack),
        .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqdata(m_reqdata), .m_reqtag(m_reqtag),
        .m_reqack(m_reqack), .m_respcyc(m_respcyc), .m_resp(m_resp), .m_resptag(m_resptag),
        .m_respack(m_respack), .m_writeack(m_writeack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_respack(input bit is_d, input logic v);
        if (is_d) begin
            d_respack = v;
            i_respack = 1'b1;
        end else begin
            i_respack = v;
            d_respack = 1'b1;
        end
    endtask

    // Starts in an IDLE cycle with the requester's reqcyc already raised.
    task automatic request_phase(input bit is_d, input logic [63:0] addr, input logic [63:0] data,
                                 input logic [12:0] tag, input int unsigned delay, input bit keep);
        #1;
        check("idle_mreqcyc", 64'(m_reqcyc), 64'd0);
        check("idle_reqack", 64'(i_reqack | d_reqack), 64'd0);
        nxt();
        for (int unsigned k = 0; k < delay; k++) begin
            #1;
            check("req_cyc_wait", 64'(m_reqcyc), 64'd1);
            check("req_addr_wait", m_req, addr);
            check("req_ack_early", 64'(i_reqack | d_reqack), 64'd0);
            nxt();
        end
        m_reqack = 1'b1;
        #1;
        check("req_cyc", 64'(m_reqcyc), 64'd1);
        check("req_addr", m_req, addr);
        check("req_data", m_reqdata, data);
        check("req_tag", 64'(m_reqtag), 64'(tag));
        check("owner_reqack", 64'(is_d ? d_reqack : i_reqack), 64'd1);
        check("other_reqack", 64'(is_d ? i_reqack : d_reqack), 64'd0);
        nxt();
        m_reqack = 1'b0;
        if (!keep) begin
            if (is_d) d_reqcyc = 1'b0;
            else      i_reqcyc = 1'b0;
        end
        #1;
        check("reqcyc_drop", 64'(m_reqcyc), 64'd0);
    endtask

    task automatic read_beats(input bit is_d, input logic [63:0] base, input logic [12:0] tag,
                              input int unsigned n, input int unsigned stall_beat,
                              input int unsigned stall_len);
        for (int unsigned b = 0; b < n; b++) begin
            m_respcyc = 1'b1;
            m_resp    = base + 64'(b);
            m_resptag = tag;
            for (int unsigned s = 0; s < ((b == stall_beat) ? stall_len : 0); s++) begin
                set_respack(is_d, 1'b0);
                #1;
                check("stall_respcyc", 64'(is_d ? d_respcyc : i_respcyc), 64'd1);
                check("stall_mrespack", 64'(m_respack), 64'd0);
                nxt();
            end
            set_respack(is_d, 1'b1);
            #1;
            check("beat_respcyc", 64'(is_d ? d_respcyc : i_respcyc), 64'd1);
            check("beat_resp", is_d ? d_resp : i_resp, base + 64'(b));
            check("beat_resptag", 64'(is_d ? d_resptag : i_resptag), 64'(tag));
            check("beat_mrespack", 64'(m_respack), 64'd1);
            check("other_respcyc", 64'(is_d ? i_respcyc : d_respcyc), 64'd0);
            check("other_resp", is_d ? i_resp : d_resp, 64'd0);
            nxt();
        end
        if (n == BURST) begin
            // Extra beat after the burst must not reach the cache.
            #1;
            check("post_burst_respcyc", 64'(is_d ? d_respcyc : i_respcyc), 64'd0);
            check("post_burst_mrespack", 64'(m_respack), 64'd0);
            m_respcyc = 1'b0;
            i_respack = 1'b0;
            d_respack = 1'b0;
        end
    endtask

    task automatic write_wait(input bit is_d, input int unsigned delay);
        for (int unsigned k = 0; k < delay; k++) begin
            m_respcyc = 1'b1;
            set_respack(is_d, 1'b1);
            #1;
            check("wr_wait_writeack", 64'(is_d ? d_writeack : i_writeack), 64'd0);
            check("wr_wait_mrespack", 64'(m_respack), 64'd0);
            check("wr_wait_respcyc", 64'(i_respcyc | d_respcyc), 64'd0);
            nxt();
        end
        m_respcyc  = 1'b0;
        m_writeack = 1'b1;
        #1;
        check("owner_writeack", 64'(is_d ? d_writeack : i_writeack), 64'd1);
        check("other_writeack", 64'(is_d ? i_writeack : d_writeack), 64'd0);
        nxt();
        #1;
        check("stray_writeack_idle", 64'(i_writeack | d_writeack), 64'd0);
        m_writeack = 1'b0;
        i_respack  = 1'b0;
        d_respack  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_reqcyc = 1'b0; i_req = '0; i_reqdata = '0; i_reqtag = '0; i_respack = 1'b0;
        d_reqcyc = 1'b0; d_req = '0; d_reqdata = '0; d_reqtag = '0; d_respack = 1'b0;
        m_reqack = 1'b0; m_respcyc = 1'b0; m_resp = '0; m_resptag = '0; m_writeack = 1'b0;
        nxt();
        // Inputs active during reset: every output must stay zero.
        i_reqcyc = 1'b1; m_reqack = 1'b1; m_respcyc = 1'b1; m_writeack = 1'b1; i_respack = 1'b1;
        #1;
        check("rst_mreqcyc", 64'(m_reqcyc), 64'd0);
        check("rst_acks", 64'({i_reqack, d_reqack, i_writeack, d_writeack}), 64'd0);
        check("rst_resp", 64'({i_respcyc, d_respcyc, m_respack}), 64'd0);
        nxt();

        // 1: I read, bus ack two cycles after the request is seen.
        reset = 1'b0; m_reqack = 1'b0; m_respcyc = 1'b0; m_writeack = 1'b0; i_respack = 1'b0;
        i_req = 64'h1000; i_reqdata = 64'h11; i_reqtag = 13'h1123;
        request_phase(1'b0, 64'h1000, 64'h11, 13'h1123, 1, 1'b0);
        read_beats(1'b0, 64'hA0, 13'h1123, BURST, BURST, 0);

        // 2: simultaneous requests after reset, D wins first.
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        i_reqcyc = 1'b1; i_req = 64'h1100; i_reqdata = 64'h22; i_reqtag = 13'h1001;
        d_reqcyc = 1'b1; d_req = 64'h2200; d_reqdata = 64'h33; d_reqtag = 13'h1ABC;
        request_phase(1'b1, 64'h2200, 64'h33, 13'h1ABC, 0, 1'b0);
        read_beats(1'b1, 64'hB0, 13'h1ABC, BURST, BURST, 0);
        request_phase(1'b0, 64'h1100, 64'h22, 13'h1001, 0, 1'b0);
        read_beats(1'b0, 64'hC0, 13'h1001, BURST, BURST, 0);

        // 3: D write.
        d_reqcyc = 1'b1; d_req = 64'h3000; d_reqdata = 64'hDEADBEEF_CAFEF00D; d_reqtag = 13'h0005;
        request_phase(1'b1, 64'h3000, 64'hDEADBEEF_CAFEF00D, 13'h0005, 1, 1'b0);
        write_wait(1'b1, 2);

        // 4: I read with a three-cycle consumer stall on beat 4.
        i_reqcyc = 1'b1; i_req = 64'h4000; i_reqdata = 64'h44; i_reqtag = 13'h1044;
        request_phase(1'b0, 64'h4000, 64'h44, 13'h1044, 0, 1'b0);
        read_beats(1'b0, 64'hD0, 13'h1044, BURST, 3, 3);

        // 5: reset after beat 3 of an I read.
        i_reqcyc = 1'b1; i_req = 64'h5000; i_reqdata = 64'h55; i_reqtag = 13'h1055;
        request_phase(1'b0, 64'h5000, 64'h55, 13'h1055, 0, 1'b0);
        read_beats(1'b0, 64'hE0, 13'h1055, 3, BURST, 0);
        reset = 1'b1; m_respcyc = 1'b1; m_resp = 64'hE3; i_respack = 1'b1;
        #1;
        check("midrst_respcyc", 64'(i_respcyc), 64'd0);
        check("midrst_mrespack", 64'(m_respack), 64'd0);
        nxt();
        reset = 1'b0; m_writeack = 1'b1;
        #1;
        check("postrst_respcyc", 64'(i_respcyc), 64'd0);
        check("postrst_resp", i_resp, 64'd0);
        check("postrst_mrespack", 64'(m_respack), 64'd0);
        check("postrst_writeack", 64'(i_writeack), 64'd0);
        check("postrst_mreqcyc", 64'(m_reqcyc), 64'd0);
        nxt();
        m_respcyc = 1'b0; m_writeack = 1'b0; i_respack = 1'b0;

        // 6: stray m_reqack in IDLE, then continuous contention alternates D,I,D,I,D,I.
        m_reqack = 1'b1;
        #1;
        check("stray_reqack", 64'(i_reqack | d_reqack), 64'd0);
        nxt();
        m_reqack = 1'b0;
        #1;
        check("stray_reqack_state", 64'(m_reqcyc), 64'd0);
        i_reqcyc = 1'b1; i_req = 64'h1111; i_reqdata = 64'h61; i_reqtag = 13'h0011;
        d_reqcyc = 1'b1; d_req = 64'h2222; d_reqdata = 64'h62; d_reqtag = 13'h0022;
        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 0) begin
                request_phase(1'b1, 64'h2222, 64'h62, 13'h0022, 0, 1'b1);
                write_wait(1'b1, 1);
            end else begin
                request_phase(1'b0, 64'h1111, 64'h61, 13'h0011, 0, 1'b1);
                write_wait(1'b0, 1);
            end
        end
        i_reqcyc = 1'b0; d_reqcyc = 1'b0;
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
